// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, 2-flop row sync, whole-scan debounce,
// single-key decode FSM and a one-entry key buffer with ready/ack handshake.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] KeyCode,
  output logic       KeyReady,
  input  logic       KeyAck,
  output logic       KeyHeld,
  output logic       Overrun
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RELEASED, PRESSED, MULTI} state_t;

  logic [3:0]    row_meta, row_sync;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic [15:0]   snap_q, prev_scan, deb_q;
  logic [15:0]   scan_full, deb_next;
  logic [SW-1:0] stable_cnt, stable_next;
  logic          armed;
  logic          dwell_end, scan_end;
  logic [4:0]    n_set;
  logic [3:0]    key_idx;
  logic          none_set, single_set;
  state_t        state_q, state_d;
  logic          emit;

  // Snapshot bit index is {col, row}, so key_idx[3:2]=column, key_idx[1:0]=row.
  function automatic logic [3:0] key_hex(input logic [3:0] idx);
    case (idx)
      4'd0:  key_hex = 4'h1;  4'd1:  key_hex = 4'h4;
      4'd2:  key_hex = 4'h7;  4'd3:  key_hex = 4'h0;
      4'd4:  key_hex = 4'h2;  4'd5:  key_hex = 4'h5;
      4'd6:  key_hex = 4'h8;  4'd7:  key_hex = 4'hF;
      4'd8:  key_hex = 4'h3;  4'd9:  key_hex = 4'h6;
      4'd10: key_hex = 4'h9;  4'd11: key_hex = 4'hE;
      4'd12: key_hex = 4'hA;  4'd13: key_hex = 4'hB;
      4'd14: key_hex = 4'hC;  default: key_hex = 4'hD;
    endcase
  endfunction

  assign dwell_end = (div_cnt == DIV_LAST);
  assign scan_end  = dwell_end && (col_idx == 2'd3);
  assign Col       = ~(4'b0001 << col_idx);
  assign KeyHeld   = (state_q == PRESSED);

  always_comb begin
    scan_full = snap_q;
    scan_full[{col_idx, 2'b00} +: 4] = ~row_sync;
    if (scan_full == prev_scan)
      stable_next = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + SW'(1);
    else
      stable_next = SW'(1);
    deb_next = (stable_next == STABLE_MAX) ? scan_full : deb_q;
  end

  always_comb begin
    n_set   = '0;
    key_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (deb_next[i]) begin
        n_set   = n_set + 5'd1;
        key_idx = 4'(i);
      end
    end
  end
  assign none_set   = (n_set == 5'd0);
  assign single_set = (n_set == 5'd1);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      row_meta   <= 4'hF;
      row_sync   <= 4'hF;
      div_cnt    <= '0;
      col_idx    <= '0;
      snap_q     <= '0;
      prev_scan  <= '0;
      deb_q      <= '0;
      stable_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      row_meta <= Row;
      row_sync <= row_meta;
      if (dwell_end) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        snap_q  <= scan_full;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (scan_end) begin
        prev_scan  <= scan_full;
        stable_cnt <= stable_next;
        deb_q      <= deb_next;
        // Events are only allowed once an all-released state has been debounced,
        // so a key held across reset cannot produce one.
        if (none_set && stable_next == STABLE_MAX) armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= RELEASED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    if (scan_end) begin
      case (state_q)
        RELEASED: begin
          if (single_set) begin
            state_d = PRESSED;
            emit    = armed;
          end else if (!none_set) begin
            state_d = MULTI;
          end
        end
        PRESSED: begin
          if (none_set)         state_d = RELEASED;
          else if (!single_set) state_d = MULTI;
        end
        default: begin
          if (none_set) state_d = RELEASED;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      KeyCode  <= 4'h0;
      KeyReady <= 1'b0;
      Overrun  <= 1'b0;
    end else if (emit) begin
      if (!KeyReady || KeyAck) begin
        KeyCode  <= key_hex(key_idx);
        KeyReady <= 1'b1;
        if (KeyReady) Overrun <= 1'b0;
      end else begin
        Overrun <= 1'b1;
      end
    end else if (KeyAck && KeyReady) begin
      KeyReady <= 1'b0;
      Overrun  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: behavioural keypad matrix plus a queue of expected key codes.
module tb_keypad_scanner;
  logic       CLK = 1'b0;
  logic       Reset;
  logic [3:0] Row;
  logic [3:0] Col;
  logic [3:0] KeyCode;
  logic       KeyReady;
  logic       KeyAck;
  logic       KeyHeld;
  logic       Overrun;

  logic [15:0] keys;
  logic [3:0]  exp_q[$];
  int checks = 0;
  int passes = 0;

  localparam int K_0 = 3, K_1 = 0, K_2 = 4, K_3 = 8, K_5 = 5;
  localparam int K_6 = 9, K_9 = 10, K_A = 12, K_D = 15;
  localparam int SCAN = 16;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .CLK(CLK), .Reset(Reset), .Row(Row), .Col(Col), .KeyCode(KeyCode),
    .KeyReady(KeyReady), .KeyAck(KeyAck), .KeyHeld(KeyHeld), .Overrun(Overrun)
  );

  always #5 CLK = ~CLK;

  // Pressed key in the driven column pulls its row low.
  always_comb begin
    Row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!Col[c])
        for (int r = 0; r < 4; r++)
          if (keys[4*c + r]) Row[r] = 1'b0;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Leaves the bench at the negedge of the first clock of a column-0 dwell.
  task automatic align_scan();
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (Col !== 4'b0111 && n < 80);
    do begin @(negedge CLK); n++; end while (Col !== 4'b1110 && n < 100);
    checks++;
    if (Col !== 4'b1110) $display("FAIL align_scan: Col=%b want 1110", Col);
    else passes++;
  endtask

  task automatic wait_ready(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge CLK);
      if (KeyReady === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic quiet_window(input int scans, output bit seen);
    seen = 1'b0;
    repeat (scans * SCAN) begin
      @(negedge CLK);
      if (KeyReady !== 1'b0) seen = 1'b1;
    end
  endtask

  task automatic pulse_ack();
    KeyAck = 1'b1;
    @(negedge CLK);
    KeyAck = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    Reset = 1'b0; KeyAck = 1'b0; keys = '0;
    repeat (3) @(negedge CLK);
    checks++; if (Col !== 4'b1110) $display("FAIL reset_col: got %b want 1110", Col); else passes++;
    checks++; if (KeyCode !== 4'h0) $display("FAIL reset_code: got %h want 0", KeyCode); else passes++;
    checks++; if (KeyReady !== 1'b0) $display("FAIL reset_ready: got %b want 0", KeyReady); else passes++;
    checks++; if (KeyHeld !== 1'b0) $display("FAIL reset_held: got %b want 0", KeyHeld); else passes++;
    checks++; if (Overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", Overrun); else passes++;
    Reset = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 80; n++) begin
      logic [3:0] want;
      want = ~(4'b0001 << ((n / 4) % 4));
      if (n % 4 == 0) begin
        checks++;
        if (Col !== want) $display("FAIL col_cycle n=%0d: got %b want %b", n, Col, want);
        else passes++;
      end
      if (KeyReady !== 1'b0) seen = 1'b1;
      @(negedge CLK);
    end
    checks++; if (seen) $display("FAIL idle_no_event: KeyReady rose with no key"); else passes++;
  endtask

  task automatic test_press_hold();
    bit seen;
    align_scan();
    keys[K_6] = 1'b1;
    exp_q.push_back(4'h6);
    repeat (31) @(negedge CLK);
    checks++; if (KeyReady !== 1'b0) $display("FAIL latency_early: KeyReady=%b want 0", KeyReady); else passes++;
    @(negedge CLK);
    checks++; if (KeyReady !== 1'b1) $display("FAIL latency_exact: KeyReady=%b want 1", KeyReady); else passes++;
    checks++; if (KeyCode !== exp_q[0]) $display("FAIL code_6: got %h want %h", KeyCode, exp_q[0]); else passes++;
    checks++; if (KeyHeld !== 1'b1) $display("FAIL held_6: got %b want 1", KeyHeld); else passes++;
    pulse_ack();
    void'(exp_q.pop_front());
    checks++; if (KeyReady !== 1'b0) $display("FAIL ack_clears: KeyReady=%b want 0", KeyReady); else passes++;
    checks++; if (KeyCode !== 4'h6) $display("FAIL code_held_after_ack: got %h want 6", KeyCode); else passes++;
    quiet_window(10, seen);
    checks++; if (seen) $display("FAIL hold_no_repeat: KeyReady rose while holding"); else passes++;
    checks++; if (KeyHeld !== 1'b1) $display("FAIL held_long: got %b want 1", KeyHeld); else passes++;
    keys = '0;
    repeat (4 * SCAN) @(negedge CLK);
    checks++; if (KeyHeld !== 1'b0) $display("FAIL release_held: got %b want 0", KeyHeld); else passes++;
  endtask

  task automatic test_overrun();
    bit ok;
    align_scan();
    keys[K_5] = 1'b1;
    exp_q.push_back(4'h5);
    wait_ready(80, ok);
    checks++; if (!ok) $display("FAIL ready_5: timeout, KeyReady=%b want 1", KeyReady); else passes++;
    checks++; if (KeyCode !== exp_q[0]) $display("FAIL code_5: got %h want %h", KeyCode, exp_q[0]); else passes++;
    keys = '0;
    repeat (4 * SCAN) @(negedge CLK);
    keys[K_D] = 1'b1;
    repeat (4 * SCAN) @(negedge CLK);
    checks++; if (Overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", Overrun); else passes++;
    checks++; if (KeyCode !== exp_q[0]) $display("FAIL overrun_keeps_old: got %h want %h", KeyCode, exp_q[0]); else passes++;
    checks++; if (KeyHeld !== 1'b1) $display("FAIL held_D: got %b want 1", KeyHeld); else passes++;
    pulse_ack();
    void'(exp_q.pop_front());
    checks++; if (KeyReady !== 1'b0) $display("FAIL overrun_ack_ready: got %b want 0", KeyReady); else passes++;
    checks++; if (Overrun !== 1'b0) $display("FAIL overrun_ack_clear: got %b want 0", Overrun); else passes++;
    keys = '0;
    repeat (4 * SCAN) @(negedge CLK);
  endtask

  task automatic test_multi();
    bit seen, ok;
    align_scan();
    keys[K_1] = 1'b1; keys[K_A] = 1'b1;
    quiet_window(4, seen);
    checks++; if (seen) $display("FAIL multi_no_event: KeyReady rose on two keys"); else passes++;
    checks++; if (KeyHeld !== 1'b0) $display("FAIL multi_held: got %b want 0", KeyHeld); else passes++;
    keys[K_A] = 1'b0;
    quiet_window(4, seen);
    checks++; if (seen) $display("FAIL multi_to_single: KeyReady rose after partial release"); else passes++;
    checks++; if (KeyHeld !== 1'b0) $display("FAIL multi_single_held: got %b want 0", KeyHeld); else passes++;
    keys = '0;
    repeat (4 * SCAN) @(negedge CLK);
    align_scan();
    keys[K_0] = 1'b1;
    exp_q.push_back(4'h0);
    wait_ready(80, ok);
    checks++; if (!ok) $display("FAIL ready_0: timeout, KeyReady=%b want 1", KeyReady); else passes++;
    checks++; if (KeyCode !== exp_q[0]) $display("FAIL code_0: got %h want %h", KeyCode, exp_q[0]); else passes++;
    pulse_ack();
    void'(exp_q.pop_front());
    keys = '0;
    repeat (4 * SCAN) @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    bit seen, ok;
    align_scan();
    keys[K_D] = 1'b1;
    repeat (SCAN) @(negedge CLK);
    keys = '0;
    quiet_window(4, seen);
    checks++; if (seen) $display("FAIL glitch_no_event: one-scan press produced a key"); else passes++;
    align_scan();
    keys[K_2] = 1'b1;
    exp_q.push_back(4'h2);
    wait_ready(80, ok);
    checks++; if (!ok) $display("FAIL ready_2: timeout, KeyReady=%b want 1", KeyReady); else passes++;
    checks++; if (KeyCode !== exp_q[0]) $display("FAIL code_2: got %h want %h", KeyCode, exp_q[0]); else passes++;
    keys = '0;
    repeat (4 * SCAN) @(negedge CLK);
    align_scan();
    keys[K_3] = 1'b1;
    exp_q.push_back(4'h3);
    repeat (31) @(negedge CLK);
    pulse_ack();
    void'(exp_q.pop_front());
    checks++; if (KeyReady !== 1'b1) $display("FAIL same_clk_ready: got %b want 1", KeyReady); else passes++;
    checks++; if (KeyCode !== exp_q[0]) $display("FAIL same_clk_code: got %h want %h", KeyCode, exp_q[0]); else passes++;
    checks++; if (Overrun !== 1'b0) $display("FAIL same_clk_overrun: got %b want 0", Overrun); else passes++;
    pulse_ack();
    void'(exp_q.pop_front());
    keys = '0;
    repeat (4 * SCAN) @(negedge CLK);
  endtask

  task automatic test_reset_midscan();
    bit seen, ok;
    align_scan();
    keys[K_9] = 1'b1;
    exp_q.push_back(4'h9);
    wait_ready(80, ok);
    checks++; if (!ok) $display("FAIL ready_9: timeout, KeyReady=%b want 1", KeyReady); else passes++;
    checks++; if (KeyCode !== exp_q[0]) $display("FAIL code_9: got %h want %h", KeyCode, exp_q[0]); else passes++;
    repeat (21) @(negedge CLK);
    #3 Reset = 1'b0;
    #1;
    exp_q.delete();
    checks++; if (Col !== 4'b1110) $display("FAIL midrst_col: got %b want 1110", Col); else passes++;
    checks++; if (KeyReady !== 1'b0) $display("FAIL midrst_ready: got %b want 0", KeyReady); else passes++;
    checks++; if (KeyCode !== 4'h0) $display("FAIL midrst_code: got %h want 0", KeyCode); else passes++;
    checks++; if (KeyHeld !== 1'b0) $display("FAIL midrst_held: got %b want 0", KeyHeld); else passes++;
    @(negedge CLK);
    Reset = 1'b1;
    quiet_window(6, seen);
    checks++; if (seen) $display("FAIL held_through_reset: key held at reset produced an event"); else passes++;
    keys = '0;
    repeat (4 * SCAN) @(negedge CLK);
    align_scan();
    keys[K_9] = 1'b1;
    exp_q.push_back(4'h9);
    wait_ready(80, ok);
    checks++; if (!ok) $display("FAIL repress_9: timeout, KeyReady=%b want 1", KeyReady); else passes++;
    checks++; if (KeyCode !== exp_q[0]) $display("FAIL repress_code: got %h want %h", KeyCode, exp_q[0]); else passes++;
    pulse_ack();
    void'(exp_q.pop_front());
    keys = '0;
  endtask

  initial begin
    test_reset();
    test_press_hold();
    test_overrun();
    test_multi();
    test_back_to_back();
    test_reset_midscan();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
